pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pll_reconfig_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_seq
// Description : PLL DRP reconfiguration sequencer. Holds the PLL in reset,
//               walks NREG ROM entries of the selected profile, and does a
//               masked read-modify-write of each DRP register. It then
//               releases the PLL reset and waits for lock. Each wait is
//               bounded by a timeout that sets a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq #(
    parameter int NREG     = 23,
    parameter int DRDY_TMO = 63,
    parameter int LOCK_TMO = 65535
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic [3:0]  SADDR,
    input  logic        SEN,
    output logic        BUSY,
    output logic        SRDY,
    output logic        ERR,
    output logic [8:0]  ROM_ADDR,
    input  logic [36:0] ROM_DATA,
    output logic [4:0]  DADDR,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    output logic        DEN,
    output logic        DWE,
    input  logic        DRDY,
    output logic        RST_PLL,
    input  logic        LOCKED
);

    // Counter widths and terminal counts. Each counter holds "cycles already
    // waited" and reaches its terminal value on the last allowed cycle.
    localparam int c_DW = (DRDY_TMO > 1) ? $clog2(DRDY_TMO) : 1;
    localparam int c_LW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
    localparam logic [c_DW-1:0] c_DRDY_LAST = c_DW'(DRDY_TMO - 1);
    localparam logic [c_LW-1:0] c_LOCK_LAST = c_LW'(LOCK_TMO - 1);
    localparam logic [4:0]      c_IDX_LAST  = 5'(NREG - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RST   = 4'd1,
        FETCH = 4'd2,
        RD    = 4'd3,
        RDW   = 4'd4,
        WR    = 4'd5,
        WRW   = 4'd6,
        NEXT  = 4'd7,
        REL   = 4'd8,
        LOCK  = 4'd9,
        DONE  = 4'd10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_profile;
    logic [4:0]        r_index;
    logic              r_fetch_ph;
    logic [4:0]        r_daddr;
    logic [15:0]       r_mask;
    logic [15:0]       r_bits;
    logic [15:0]       r_di;
    logic              r_err;
    logic [c_DW-1:0]   r_dcnt;
    logic [c_LW-1:0]   r_lcnt;
    logic              w_drdy_last;
    logic              w_lock_last;

    assign w_drdy_last = (r_dcnt == c_DRDY_LAST);
    assign w_lock_last = (r_lcnt == c_LOCK_LAST);

    // The ROM address always follows the latched profile and current index
    assign ROM_ADDR = {r_profile, r_index};
    assign DADDR    = r_daddr;
    assign DI       = r_di;
    assign ERR      = r_err;

    // State register; an asynchronous reset aborts any sequence immediately
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_state_nxt = r_state;
        BUSY        = 1'b1;
        SRDY        = 1'b0;
        DEN         = 1'b0;
        DWE         = 1'b0;
        RST_PLL     = 1'b0;
        case (r_state)
            IDLE: begin
                BUSY = 1'b0;
                if (SEN) begin
                    w_state_nxt = RST;
                end
            end
            RST: begin
                RST_PLL     = 1'b1;
                w_state_nxt = FETCH;
            end
            FETCH: begin
                // first phase presents the address, second captures the data
                RST_PLL = 1'b1;
                if (r_fetch_ph) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                RST_PLL     = 1'b1;
                DEN         = 1'b1;
                w_state_nxt = RDW;
            end
            RDW: begin
                RST_PLL = 1'b1;
                if (DRDY) begin
                    w_state_nxt = WR;
                end else if (w_drdy_last) begin
                    w_state_nxt = DONE;
                end
            end
            WR: begin
                RST_PLL     = 1'b1;
                DEN         = 1'b1;
                DWE         = 1'b1;
                w_state_nxt = WRW;
            end
            WRW: begin
                RST_PLL = 1'b1;
                if (DRDY) begin
                    w_state_nxt = NEXT;
                end else if (w_drdy_last) begin
                    w_state_nxt = DONE;
                end
            end
            NEXT: begin
                RST_PLL     = 1'b1;
                w_state_nxt = (r_index == c_IDX_LAST) ? REL : FETCH;
            end
            REL: begin
                w_state_nxt = LOCK;
            end
            LOCK: begin
                if (LOCKED || w_lock_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                SRDY        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                BUSY        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: profile/index, ROM entry capture, RMW data, timeouts, error flag
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_profile  <= 4'd0;
            r_index    <= 5'd0;
            r_fetch_ph <= 1'b0;
            r_daddr    <= 5'd0;
            r_mask     <= 16'd0;
            r_bits     <= 16'd0;
            r_di       <= 16'd0;
            r_err      <= 1'b0;
            r_dcnt     <= '0;
            r_lcnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (SEN) begin
                        r_profile  <= SADDR;
                        r_index    <= 5'd0;
                        r_fetch_ph <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                FETCH: begin
                    r_fetch_ph <= ~r_fetch_ph;
                    if (r_fetch_ph) begin
                        r_daddr <= ROM_DATA[36:32];
                        r_mask  <= ROM_DATA[31:16];
                        r_bits  <= ROM_DATA[15:0];
                    end
                end
                RD, WR: begin
                    r_dcnt <= '0;
                end
                RDW: begin
                    // mask bits keep the live register value, the rest come from the ROM
                    if (DRDY) begin
                        r_di <= (DO & r_mask) | (r_bits & ~r_mask);
                    end else if (w_drdy_last) begin
                        r_err <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                WRW: begin
                    if (!DRDY) begin
                        if (w_drdy_last) begin
                            r_err <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (r_index != c_IDX_LAST) begin
                        r_index <= r_index + 5'd1;
                    end
                end
                REL: begin
                    r_lcnt <= '0;
                end
                LOCK: begin
                    if (!LOCKED) begin
                        if (w_lock_last) begin
                            r_err <= 1'b1;
                        end else begin
                            r_lcnt <= r_lcnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reconfig_seq
// Description : Directed self-checking bench for pll_reconfig_seq with a
//               synchronous ROM model, a DRP register-file model and a
//               LOCKED model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic [3:0]  SADDR = 4'd0;
    logic        SEN = 1'b0;
    wire         BUSY, SRDY, ERR, DEN, DWE, RST_PLL;
    wire  [8:0]  ROM_ADDR;
    wire  [4:0]  DADDR;
    wire  [15:0] DI;
    logic [36:0] ROM_DATA;
    logic [15:0] DO;
    logic        DRDY;
    logic        LOCKED;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pll_reconfig_seq dut (
        .CLK(CLK), .RSTX(RSTX), .SADDR(SADDR), .SEN(SEN), .BUSY(BUSY),
        .SRDY(SRDY), .ERR(ERR), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
        .DADDR(DADDR), .DI(DI), .DO(DO), .DEN(DEN), .DWE(DWE), .DRDY(DRDY),
        .RST_PLL(RST_PLL), .LOCKED(LOCKED)
    );

    // ROM contents and DRP power-on register values
    function automatic logic [15:0] f_mask(input int i);
        return 16'h00F0 ^ 16'(i * 16'h0901);
    endfunction
    function automatic logic [15:0] f_bits(input int i);
        return 16'h1234 + 16'(i * 16'h0111);
    endfunction
    function automatic logic [15:0] f_init(input int a);
        return (a == 0) ? 16'hFFFF : (16'hC3C3 ^ 16'(a * 16'h0805));
    endfunction
    function automatic logic [15:0] f_exp_di(input int i);
        return (f_init(i) & f_mask(i)) | (f_bits(i) & ~f_mask(i));
    endfunction

    // Synchronous ROM: data valid one cycle after the address
    logic [36:0] rom [0:511];
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    // DRP model: DRDY two cycles after DEN; drop_on=N withholds DRDY on the Nth read
    logic        clr = 1'b0;
    int          drop_on = 0;
    bit          lock_en = 1'b1;
    logic [15:0] mem [0:31];
    int          m_rd;
    logic        req_v, req_we, req_drop;
    logic [4:0]  req_a;
    logic [15:0] req_d;
    always @(posedge CLK) begin
        if (clr) begin
            for (int a = 0; a < 32; a++) mem[a] <= f_init(a);
            m_rd <= 0; req_v <= 1'b0; req_drop <= 1'b0; DRDY <= 1'b0; DO <= 16'h0;
        end else begin
            DRDY <= 1'b0;
            if (req_v && !req_drop) begin
                DRDY <= 1'b1;
                DO   <= mem[req_a];
                if (req_we) mem[req_a] <= req_d;
            end
            req_v    <= DEN;
            req_a    <= DADDR;
            req_we   <= DWE;
            req_d    <= DI;
            req_drop <= DEN && !DWE && (m_rd + 1 == drop_on);
            if (DEN && !DWE) m_rd <= m_rd + 1;
        end
    end

    // LOCKED model: locks six cycles after PLL reset release when enabled
    int lk;
    always @(posedge CLK) begin
        if (RST_PLL || !lock_en) begin
            lk <= 0; LOCKED <= 1'b0;
        end else if (lk < 5) begin
            lk <= lk + 1;
        end else begin
            LOCKED <= 1'b1;
        end
    end

    // Observation of DRP traffic and handshakes, sampled on the falling edge
    int          cyc, mon_rd, mon_wr, srdy_cnt, srdy_cyc, den3_cyc;
    int          relock, rst_bad, overlap, den_total;
    bit          outstanding, srdy_rst, srdy_err;
    logic [8:0]  rd_rom [0:63];
    logic [4:0]  wr_a   [0:63];
    logic [15:0] wr_d   [0:63];
    always @(negedge CLK) begin
        if (clr) begin
            cyc = 0; mon_rd = 0; mon_wr = 0; srdy_cnt = 0; srdy_cyc = 0; den3_cyc = 0;
            relock = 0; rst_bad = 0; overlap = 0; den_total = 0;
            outstanding = 0; srdy_rst = 0; srdy_err = 0;
        end else begin
            cyc++;
            if (DEN && outstanding) overlap++;
            if (DRDY) outstanding = 0;
            if (DEN) begin
                outstanding = 1;
                den_total++;
                if (!RST_PLL) rst_bad++;
            end
            if (DEN && !DWE) begin
                if (mon_rd < 64) rd_rom[mon_rd] = ROM_ADDR;
                mon_rd++;
                if (mon_rd == 3) den3_cyc = cyc;
            end
            if (DEN && DWE) begin
                if (mon_wr < 64) begin
                    wr_a[mon_wr] = DADDR;
                    wr_d[mon_wr] = DI;
                end
                mon_wr++;
            end
            if (SRDY) begin
                srdy_cnt++; srdy_cyc = cyc; srdy_rst = RST_PLL; srdy_err = ERR;
            end
            if (BUSY && !RST_PLL && !SRDY) relock++;
        end
    end

    task automatic do_clear;
        @(posedge CLK); #1 clr = 1'b1;
        @(posedge CLK); #1 clr = 1'b0;
    endtask

    task automatic pulse_sen(input logic [3:0] a);
        @(negedge CLK); SADDR = a; SEN = 1'b1;
        @(negedge CLK); SEN = 1'b0;
    endtask

    task automatic wait_srdy(input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge CLK);
            if (SRDY) ok = 1'b1;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RSTX = 1'b0;
        do_clear();
        @(negedge CLK);
        total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        total++; if (SRDY !== 1'b0)     begin bad++; $display("FAIL rst_srdy got=%b exp=0", SRDY); end
        total++; if (ERR !== 1'b0)      begin bad++; $display("FAIL rst_err got=%b exp=0", ERR); end
        total++; if (DEN !== 1'b0 || DWE !== 1'b0) begin bad++; $display("FAIL rst_den_dwe got=%b%b exp=00", DEN, DWE); end
        total++; if (DADDR !== 5'd0)    begin bad++; $display("FAIL rst_daddr got=%h exp=0", DADDR); end
        total++; if (DI !== 16'd0)      begin bad++; $display("FAIL rst_di got=%h exp=0", DI); end
        total++; if (ROM_ADDR !== 9'd0) begin bad++; $display("FAIL rst_rom_addr got=%h exp=0", ROM_ADDR); end
        total++; if (RST_PLL !== 1'b0)  begin bad++; $display("FAIL rst_rst_pll got=%b exp=0", RST_PLL); end
        RSTX = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_full_sequence;
        bit ok;
        do_clear();
        lock_en = 1'b1; drop_on = 0;
        pulse_sen(4'd5);
        repeat (10) @(negedge CLK);
        pulse_sen(4'd9);               // arrives while busy, must be ignored
        wait_srdy(3000, ok);
        total++; if (!ok)              begin bad++; $display("FAIL full_srdy_timeout got=none exp=pulse"); end
        total++; if (mon_rd !== 23)    begin bad++; $display("FAIL full_reads got=%0d exp=23", mon_rd); end
        total++; if (mon_wr !== 23)    begin bad++; $display("FAIL full_writes got=%0d exp=23", mon_wr); end
        for (int k = 0; k < 23; k++) begin
            total++; if (rd_rom[k] !== 9'(32'h0A0 + k)) begin bad++; $display("FAIL full_rom_addr[%0d] got=%h exp=%h", k, rd_rom[k], 9'(32'h0A0 + k)); end
            total++; if (wr_a[k] !== 5'(k)) begin bad++; $display("FAIL full_wr_addr[%0d] got=%h exp=%h", k, wr_a[k], 5'(k)); end
            total++; if (wr_d[k] !== f_exp_di(k)) begin bad++; $display("FAIL full_wr_data[%0d] got=%h exp=%h", k, wr_d[k], f_exp_di(k)); end
        end
        // register 0: DO=FFFF, mask=00F0, bits=1234
        total++; if (wr_d[0] !== 16'h12F4) begin bad++; $display("FAIL full_rmw0 got=%h exp=12F4", wr_d[0]); end
        total++; if (srdy_cnt !== 1)   begin bad++; $display("FAIL full_srdy_count got=%0d exp=1", srdy_cnt); end
        total++; if (ERR !== 1'b0)     begin bad++; $display("FAIL full_err got=%b exp=0", ERR); end
        total++; if (rst_bad !== 0)    begin bad++; $display("FAIL full_rst_pll_low_during_drp got=%0d exp=0", rst_bad); end
        total++; if (overlap !== 0)    begin bad++; $display("FAIL full_den_overlap got=%0d exp=0", overlap); end
        total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL full_busy_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_drdy_timeout;
        bit ok;
        do_clear();
        lock_en = 1'b1; drop_on = 3;
        pulse_sen(4'd5);
        wait_srdy(2000, ok);
        total++; if (!ok)              begin bad++; $display("FAIL tmo_srdy_timeout got=none exp=pulse"); end
        total++; if (srdy_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", srdy_err); end
        total++; if (srdy_rst !== 1'b0) begin bad++; $display("FAIL tmo_rst_pll got=%b exp=0", srdy_rst); end
        total++; if (srdy_cyc - den3_cyc !== 64) begin bad++; $display("FAIL tmo_latency got=%0d exp=64", srdy_cyc - den3_cyc); end
        total++; if (mon_wr !== 2)     begin bad++; $display("FAIL tmo_writes got=%0d exp=2", mon_wr); end
        total++; if (mon_rd !== 3)     begin bad++; $display("FAIL tmo_reads got=%0d exp=3", mon_rd); end
        total++; if (srdy_cnt !== 1)   begin bad++; $display("FAIL tmo_srdy_count got=%0d exp=1", srdy_cnt); end
        total++; if (ERR !== 1'b1)     begin bad++; $display("FAIL tmo_err_sticky got=%b exp=1", ERR); end
        drop_on = 0;
    endtask

    task automatic test_lock_timeout;
        bit ok;
        do_clear();
        lock_en = 1'b0; drop_on = 0;
        pulse_sen(4'd5);
        total++; if (ERR !== 1'b0)     begin bad++; $display("FAIL lock_err_cleared_by_sen got=%b exp=0", ERR); end
        wait_srdy(70000, ok);
        total++; if (!ok)              begin bad++; $display("FAIL lock_srdy_timeout got=none exp=pulse"); end
        total++; if (srdy_err !== 1'b1) begin bad++; $display("FAIL lock_err got=%b exp=1", srdy_err); end
        total++; if (relock !== 65536) begin bad++; $display("FAIL lock_wait_cycles got=%0d exp=65536", relock); end
        total++; if (srdy_cnt !== 1)   begin bad++; $display("FAIL lock_srdy_count got=%0d exp=1", srdy_cnt); end
        lock_en = 1'b1;
        pulse_sen(4'd5);
        total++; if (ERR !== 1'b0 || BUSY !== 1'b1) begin bad++; $display("FAIL lock_resen_err_busy got=%b%b exp=01", ERR, BUSY); end
        wait_srdy(3000, ok);
        total++; if (!ok || ERR !== 1'b0) begin bad++; $display("FAIL lock_clean_rerun got=ok%0d err%b exp=ok1 err0", ok, ERR); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int den_before;
        do_clear();
        lock_en = 1'b1; drop_on = 0;
        pulse_sen(4'd5);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge CLK);
            if (DEN && DWE) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_no_write got=none exp=write"); end
        @(negedge CLK);                // now waiting for the write DRDY
        RSTX = 1'b0;
        #1;
        total++; if (BUSY !== 1'b0 || SRDY !== 1'b0 || ERR !== 1'b0) begin bad++; $display("FAIL mid_status got=%b%b%b exp=000", BUSY, SRDY, ERR); end
        total++; if (DEN !== 1'b0 || DWE !== 1'b0 || RST_PLL !== 1'b0) begin bad++; $display("FAIL mid_ctrl got=%b%b%b exp=000", DEN, DWE, RST_PLL); end
        total++; if (DADDR !== 5'd0 || DI !== 16'd0 || ROM_ADDR !== 9'd0) begin bad++; $display("FAIL mid_bus got=%h/%h/%h exp=0/0/0", DADDR, DI, ROM_ADDR); end
        @(negedge CLK);
        RSTX = 1'b1;
        den_before = den_total;
        repeat (50) @(negedge CLK);
        total++; if (den_total !== den_before) begin bad++; $display("FAIL mid_den_after_release got=%0d exp=%0d", den_total, den_before); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy_after_release got=%b exp=0", BUSY); end
    endtask

    initial begin
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < 32; i++) begin
                rom[p * 32 + i] = {((p == 5) ? 5'(i) : 5'(31 - i)), f_mask(i), f_bits(i)};
            end
        end
        test_reset();
        test_full_sequence();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
